spsram_ctrl: RTL

SPSRAM_CTRL -- requirements
Module: spsram_ctrl

---
 rtl/spsram_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/spsram_ctrl.sv
// Single-port SRAM controller: clears the array after reset, then forwards
// read/write requests and returns read data in order through a 3-entry response FIFO.
module spsram_ctrl #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [DEPTH_LOG-1:0] req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 init_done,
  output logic                 cs,
  output logic                 we,
  output logic [DEPTH_LOG-1:0] ad,
  output logic [WIDTH-1:0]     din,
  input  logic [WIDTH-1:0]     dout
);

  typedef enum logic {INIT, RUN} state_t;

  state_t               state, state_nxt;
  logic [DEPTH_LOG-1:0] init_cnt;
  logic [1:0]           outstanding;
  logic                 inflight;
  logic [WIDTH-1:0]     fifo_mem [3];
  logic [1:0]           wr_ptr, rd_ptr, fifo_cnt;
  logic                 rd_acc, push, pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    init_done = 1'b0;
    cs        = 1'b0;
    we        = 1'b0;
    ad        = '0;
    din       = '0;
    case (state)
      INIT: begin
        cs = 1'b1;
        we = 1'b1;
        ad = init_cnt;
        if (init_cnt == DEPTH_LOG'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        init_done = 1'b1;
        req_ready = (outstanding != 2'd3);
        cs        = req_valid & req_ready;
        if (cs) begin
          we  = req_we;
          ad  = req_addr;
          din = req_wdata;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign rd_acc    = (state == RUN) & cs & ~we;
  assign push      = inflight;
  assign rsp_valid = (fifo_cnt != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      outstanding <= 2'd0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      fifo_cnt    <= 2'd0;
    end else begin
      inflight <= rd_acc;
      case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dout;
  end

  // Outstanding reads cap FIFO occupancy plus the in-flight slot at 3.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_cnt == 2'd3));

endmodule
